lsu_unit: RTL and testbench

Load/store stage of the multi-cycle NPC core. It is the consumer end of the EXU→LSU valid/ready handshake. It accepts the 109-bit execute packet and performs any load or store over a simple request/response memory port. It then presents a 38-bit writeback packet to the WBU through a second valid/ready handshake.

---
 rtl/lsu_unit_if.sv | 73 +++++++
 rtl/lsu_unit.sv | 144 ++++++++++++++
 tb/tb_lsu_unit.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_unit_if.sv
// Handshake bundles around the load/store stage:
// EXU->LSU packet, LSU->WBU packet and the LSU memory port.
interface exu_lsu_if;
    logic         exu_valid;
    logic [108:0] exu_data;
    logic         lsu_ready;

    modport master (
        output exu_valid,
        output exu_data,
        input  lsu_ready
    );

    modport slave (
        input  exu_valid,
        input  exu_data,
        output lsu_ready
    );
endinterface

interface lsu_wbu_if;
    logic        lsu_valid;
    logic [37:0] lsu_data;
    logic        wbu_ready;

    modport master (
        output lsu_valid,
        output lsu_data,
        input  wbu_ready
    );

    modport slave (
        input  lsu_valid,
        input  lsu_data,
        output wbu_ready
    );
endinterface

interface lsu_mem_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req_valid,
        input  mem_req_ready,
        output mem_req_wen,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_rsp_valid,
        output mem_rsp_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_req_wen,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_rsp_valid,
        input  mem_rsp_ready,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_unit.sv
// Load/store stage: captures the execute packet, runs one memory
// request/response if needed, then hands a writeback packet to WBU.
module lsu_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    exu_lsu_if.slave   exu,
    lsu_wbu_if.master  wbu,
    lsu_mem_if.master  mem
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_WB
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] alu;
        logic [WIDTH-1:0] sd;
        logic             ren;
        logic             wen;
        logic [2:0]       op;
        logic [4:0]       rd;
        logic             reg_wen;
        logic [1:0]       wb_sel;
        logic [WIDTH-1:0] csr;
    } exu_pkt_t;

    state_t           state;
    state_t           state_nxt;
    exu_pkt_t         pkt;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] load_nxt;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rd_wdata;
    logic [3:0]       strb;
    logic [1:0]       off;
    logic             hs;
    logic             rsp_hs;
    logic             in_mem;

    assign hs     = exu.exu_valid & exu.lsu_ready;
    assign rsp_hs = mem.mem_rsp_valid & mem.mem_rsp_ready;
    assign in_mem = exu.exu_data[44] | exu.exu_data[43];
    assign off    = pkt.alu[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pkt      <= '0;
            load_val <= '0;
        end else begin
            state <= state_nxt;
            if (hs)
                pkt <= exu.exu_data;
            // only a read updates the load value
            if (rsp_hs && pkt.ren && !pkt.wen)
                load_val <= load_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (exu.exu_valid)
                    state_nxt = in_mem ? S_REQ : S_WB;
            end
            S_REQ: begin
                if (mem.mem_req_ready)
                    state_nxt = S_RESP;
            end
            S_RESP: begin
                if (mem.mem_rsp_valid)
                    state_nxt = S_WB;
            end
            S_WB: begin
                if (wbu.wbu_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        strb  = 4'b0000;
        wdata = pkt.sd;
        unique case (pkt.op)
            3'b000: begin
                strb  = 4'b0001 << off;
                wdata = {4{pkt.sd[7:0]}};
            end
            3'b001: begin
                strb  = 4'b0011 << off;
                wdata = {2{pkt.sd[15:0]}};
            end
            3'b010: begin
                strb  = 4'b1111;
                wdata = pkt.sd;
            end
            default: begin
                strb  = 4'b0000;
                wdata = pkt.sd;
            end
        endcase
    end

    always_comb begin
        shifted  = mem.mem_rdata >> {off, 3'b000};
        load_nxt = '0;
        unique case (pkt.op)
            3'b000:  load_nxt = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_nxt = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_nxt = shifted;
            3'b100:  load_nxt = {24'b0, shifted[7:0]};
            3'b101:  load_nxt = {16'b0, shifted[15:0]};
            default: load_nxt = '0;
        endcase
    end

    always_comb begin
        rd_wdata = pkt.alu;
        unique case (pkt.wb_sel)
            2'b01:   rd_wdata = load_val;
            2'b10:   rd_wdata = pkt.csr;
            default: rd_wdata = pkt.alu;
        endcase
    end

    assign exu.lsu_ready     = (state == S_IDLE);
    assign wbu.lsu_valid     = (state == S_WB);
    assign wbu.lsu_data      = {rd_wdata, pkt.rd, pkt.reg_wen};
    assign mem.mem_req_valid = (state == S_REQ);
    assign mem.mem_rsp_ready = (state == S_RESP);
    assign mem.mem_req_wen   = pkt.wen;
    assign mem.mem_addr      = {pkt.alu[31:2], 2'b00};
    assign mem.mem_wdata     = wdata;
    assign mem.mem_wstrb     = pkt.wen ? strb : 4'b0000;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit with a transaction-level reference
// model checked on every falling clock edge.
module tb_lsu_unit;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         exu_valid = 1'b0;
    logic [108:0] exu_data = '0;
    logic         wbu_ready = 1'b0;
    logic         mem_req_ready = 1'b0;
    logic         mem_rsp_valid = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic         lsu_ready;
    logic         lsu_valid;
    logic [37:0]  lsu_data;
    logic         mem_req_valid;
    logic         mem_req_wen;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_wstrb;
    logic         mem_rsp_ready;

    int tests = 0;
    int fails = 0;

    exu_lsu_if exu_if ();
    lsu_wbu_if wbu_if ();
    lsu_mem_if mem_if ();

    assign exu_if.exu_valid     = exu_valid;
    assign exu_if.exu_data      = exu_data;
    assign wbu_if.wbu_ready     = wbu_ready;
    assign mem_if.mem_req_ready = mem_req_ready;
    assign mem_if.mem_rsp_valid = mem_rsp_valid;
    assign mem_if.mem_rdata     = mem_rdata;
    assign lsu_ready     = exu_if.lsu_ready;
    assign lsu_valid     = wbu_if.lsu_valid;
    assign lsu_data      = wbu_if.lsu_data;
    assign mem_req_valid = mem_if.mem_req_valid;
    assign mem_req_wen   = mem_if.mem_req_wen;
    assign mem_addr      = mem_if.mem_addr;
    assign mem_wdata     = mem_if.mem_wdata;
    assign mem_wstrb     = mem_if.mem_wstrb;
    assign mem_rsp_ready = mem_if.mem_rsp_ready;

    lsu_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .exu (exu_if),
        .wbu (wbu_if),
        .mem (mem_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [108:0] mk(
        input logic [31:0] a, input logic [31:0] sd,
        input logic ren, input logic wen, input logic [2:0] op,
        input logic [4:0] rd, input logic rwen,
        input logic [1:0] wbs, input logic [31:0] csr);
        return {a, sd, ren, wen, op, rd, rwen, wbs, csr};
    endfunction

    function automatic logic [37:0] exp_wb(input logic [108:0] p,
                                          input logic [31:0] rdata);
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] lv;
        logic [31:0] v;
        int off;
        a   = p[108:77];
        off = int'(a[1:0]);
        w   = rdata >> (8 * off);
        b   = w & 32'hFF;
        h   = w & 32'hFFFF;
        case (int'(p[42:40]))
            0:       lv = (b >= 32'd128) ? b - 32'd256 : b;
            1:       lv = (h >= 32'd32768) ? h - 32'd65536 : h;
            2:       lv = w;
            4:       lv = b;
            5:       lv = h;
            default: lv = 32'd0;
        endcase
        case (int'(p[33:32]))
            1:       v = lv;
            2:       v = p[31:0];
            default: v = a;
        endcase
        return {v, p[39:35], p[34]};
    endfunction

    function automatic logic [3:0] exp_strb(input logic [108:0] p);
        int off;
        int s;
        off = int'(p[78:77]);
        s = 0;
        if (p[43]) begin
            case (int'(p[42:40]))
                0: s = (1 << off) & 15;
                1: s = (3 << off) & 15;
                2: s = 15;
                default: s = 0;
            endcase
        end
        return 4'(s);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [108:0] p);
        logic [31:0] sd;
        sd = p[76:45];
        case (int'(p[42:40]))
            0:       return (sd & 32'hFF) * 32'h0101_0101;
            1:       return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    // transaction-level model: busy, memory phase, request done
    logic         m_busy = 1'b0;
    logic         m_mpend = 1'b0;
    logic         m_rqdone = 1'b0;
    logic [108:0] m_pkt = '0;
    logic [31:0]  m_rdata = '0;

    always @(negedge clk) begin
        logic acc;
        logic wb_hs;
        logic rq_hs;
        logic rs_hs;
        if (!rst) begin
            m_busy = 0;
            m_mpend = 0;
            m_rqdone = 0;
            m_pkt = '0;
            m_rdata = '0;
            chk("rst_lsu_valid", lsu_valid, 0);
            chk("rst_req_valid", mem_req_valid, 0);
            chk("rst_rsp_ready", mem_rsp_ready, 0);
            chk("rst_lsu_data", lsu_data, 0);
            chk("rst_req_fields",
                {mem_req_wen, mem_addr, mem_wdata, mem_wstrb}, 0);
        end else begin
            chk("m_lsu_ready", lsu_ready, !m_busy);
            chk("m_lsu_valid", lsu_valid, m_busy && !m_mpend);
            chk("m_req_valid", mem_req_valid, m_mpend && !m_rqdone);
            chk("m_rsp_ready", mem_rsp_ready, m_mpend && m_rqdone);
            if (lsu_valid)
                chk("m_lsu_data", lsu_data, exp_wb(m_pkt, m_rdata));
            if (mem_req_valid) begin
                chk("m_req_wen", mem_req_wen, m_pkt[43]);
                chk("m_req_addr", mem_addr, m_pkt[108:77] & ~32'd3);
                chk("m_req_strb", mem_wstrb, exp_strb(m_pkt));
                if (m_pkt[43])
                    chk("m_req_wdata", mem_wdata, exp_wdata(m_pkt));
            end
            acc   = exu_valid && !m_busy;
            wb_hs = m_busy && !m_mpend && wbu_ready;
            rq_hs = m_mpend && !m_rqdone && mem_req_ready;
            rs_hs = m_mpend && m_rqdone && mem_rsp_valid;
            if (wb_hs)
                m_busy = 0;
            if (rq_hs)
                m_rqdone = 1;
            if (rs_hs) begin
                m_mpend = 0;
                if (!m_pkt[43])
                    m_rdata = mem_rdata;
            end
            if (acc) begin
                m_pkt = exu_data;
                m_busy = 1;
                m_mpend = exu_data[44] | exu_data[43];
                m_rqdone = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(
        input logic [108:0] p, input logic [31:0] rdata,
        input int rq_d, input int rs_d, input int wb_d,
        input bit pre_wb,
        output logic [37:0] wb_out, output int lat,
        output logic [31:0] ra, output logic [3:0] rstrb,
        output logic [31:0] rwd, output logic rwen);
        int n;
        ra = '0;
        rstrb = '0;
        rwd = '0;
        rwen = 1'b0;
        exu_valid = 1;
        exu_data = p;
        wbu_ready = pre_wb;
        n = 0;
        while (!lsu_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("tmo_lsu_ready", 1, 0);
        step();
        exu_valid = 0;
        if (p[44] | p[43]) begin
            n = 0;
            while (!mem_req_valid && n < 100) begin
                step();
                n++;
            end
            if (n >= 100) chk("tmo_req_valid", 1, 0);
            ra = mem_addr;
            rstrb = mem_wstrb;
            rwd = mem_wdata;
            rwen = mem_req_wen;
            repeat (rq_d) step();
            mem_req_ready = 1;
            step();
            mem_req_ready = 0;
            repeat (rs_d) step();
            mem_rdata = rdata;
            mem_rsp_valid = 1;
            step();
            mem_rsp_valid = 0;
        end
        lat = 0;
        while (!lsu_valid && lat < 100) begin
            step();
            lat++;
        end
        if (lat >= 100) chk("tmo_lsu_valid", 1, 0);
        wb_out = lsu_data;
        repeat (wb_d) step();
        wbu_ready = 1;
        step();
        wbu_ready = 0;
    endtask

    task automatic run(
        input string nm, input logic [108:0] p,
        input logic [31:0] rdata, input int rq, input int rs,
        input int wb, input logic [31:0] e_rdw,
        input logic [3:0] e_strb, input logic [31:0] e_wd);
        logic [37:0] wbo;
        int lat;
        logic [31:0] ra;
        logic [3:0] rs_b;
        logic [31:0] rwd;
        logic rwen;
        txn(p, rdata, rq, rs, wb, 0, wbo, lat, ra, rs_b, rwd, rwen);
        chk({nm, "_rdw"}, wbo[37:6], e_rdw);
        if (p[44] | p[43]) begin
            chk({nm, "_strb"}, rs_b, e_strb);
            chk({nm, "_wen"}, rwen, p[43]);
            if (p[43])
                chk({nm, "_wdata"}, rwd, e_wd);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [37:0] wbo;
        int lat;
        logic [31:0] ra;
        logic [3:0] rs_b;
        logic [31:0] rwd;
        logic rwen;
        logic [108:0] pa;
        logic [108:0] pb;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_lsu_ready", lsu_ready, 1);
        chk("reset_lsu_valid", lsu_valid, 0);
        chk("reset_req_valid", mem_req_valid, 0);
        rst = 1;
        step();

        // ALU packet with wbu_ready already high
        txn(mk(32'h1234_5678, 0, 0, 0, 3'b000, 5'd5, 1, 2'b00, 0),
            0, 0, 0, 0, 1, wbo, lat, ra, rs_b, rwd, rwen);
        chk("alu_data", wbo, {32'h1234_5678, 5'd5, 1'b1});
        chk("alu_latency", lat, 0);

        // LB sign-extend with 2-cycle memory delays
        txn(mk(32'h8000_0003, 0, 1, 0, 3'b000, 5'd7, 1, 2'b01, 0),
            32'h80AA_BBCC, 2, 2, 0, 0, wbo, lat, ra, rs_b, rwd, rwen);
        chk("lb_addr", ra, 32'h8000_0000);
        chk("lb_rdw", wbo[37:6], 32'hFFFF_FF80);
        chk("lb_strb", rs_b, 4'b0000);
        chk("lb_wen", rwen, 0);

        run("sh", mk(32'h8000_0002, 32'hDEAD_BEEF, 0, 1, 3'b001,
            5'd0, 0, 2'b00, 0), 0, 1, 1, 0,
            32'h8000_0002, 4'b1100, 32'hBEEF_BEEF);
        run("lhu", mk(32'h8000_0001, 0, 1, 0, 3'b101,
            5'd9, 1, 2'b01, 0), 32'h00FF_FE00, 4, 0, 0,
            32'h0000_FFFE, 4'b0000, 0);
        run("sb", mk(32'h1000_0001, 32'h0000_00A5, 0, 1, 3'b000,
            5'd0, 0, 2'b00, 0), 0, 0, 0, 0,
            32'h1000_0001, 4'b0010, 32'hA5A5_A5A5);
        run("sw", mk(32'h1000_0004, 32'hCAFE_F00D, 0, 1, 3'b010,
            5'd0, 0, 2'b00, 0), 0, 1, 3, 1,
            32'h1000_0004, 4'b1111, 32'hCAFE_F00D);
        run("lw", mk(32'h2000_0008, 0, 1, 0, 3'b010,
            5'd1, 1, 2'b01, 0), 32'h1357_9BDF, 0, 1, 0,
            32'h1357_9BDF, 4'b0000, 0);
        run("lh", mk(32'h2000_000A, 0, 1, 0, 3'b001,
            5'd2, 1, 2'b01, 0), 32'h8001_1234, 1, 0, 2,
            32'hFFFF_8001, 4'b0000, 0);
        run("lbu", mk(32'h2000_0001, 0, 1, 0, 3'b100,
            5'd3, 1, 2'b01, 0), 32'h1234_80FF, 0, 0, 0,
            32'h0000_0080, 4'b0000, 0);
        run("csr", mk(32'h0000_0010, 0, 0, 0, 3'b000,
            5'd4, 1, 2'b10, 32'hABCD_0001), 0, 0, 0, 1,
            32'hABCD_0001, 4'b0000, 0);
        run("renwen", mk(32'h3000_0000, 32'h1122_3344, 1, 1, 3'b010,
            5'd0, 0, 2'b00, 0), 0, 0, 0, 0,
            32'h3000_0000, 4'b1111, 32'h1122_3344);
        run("st_bad", mk(32'h3000_0004, 32'h5555_AAAA, 0, 1, 3'b011,
            5'd0, 0, 2'b00, 0), 0, 0, 0, 0,
            32'h3000_0004, 4'b0000, 32'h5555_AAAA);
        run("ld_bad", mk(32'h3000_0008, 0, 1, 0, 3'b011,
            5'd6, 1, 2'b01, 0), 32'hFFFF_FFFF, 0, 0, 0,
            32'h0000_0000, 4'b0000, 0);
        run("sh_off3", mk(32'h3000_0007, 32'h0000_1234, 0, 1, 3'b001,
            5'd0, 0, 2'b00, 0), 0, 0, 0, 0,
            32'h3000_0007, 4'b1000, 32'h1234_1234);
        run("wbs11", mk(32'h0BAD_F00D, 0, 0, 0, 3'b000,
            5'd31, 1, 2'b11, 32'h1111_1111), 0, 0, 0, 0,
            32'h0BAD_F00D, 4'b0000, 0);

        // backpressure with the next packet waiting on exu_valid
        pa = mk(32'h0000_00AA, 0, 0, 0, 3'b000, 5'd3, 1, 2'b00, 0);
        pb = mk(32'h0000_00BB, 0, 0, 0, 3'b000, 5'd4, 0, 2'b00, 0);
        exu_valid = 1;
        exu_data = pa;
        step();
        exu_data = pb;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", lsu_valid, 1);
            chk("bp_ready", lsu_ready, 0);
            chk("bp_data", lsu_data, {32'h0000_00AA, 5'd3, 1'b1});
            step();
        end
        wbu_ready = 1;
        step();
        wbu_ready = 0;
        chk("bp_gap_valid", lsu_valid, 0);
        chk("bp_gap_ready", lsu_ready, 1);
        step();
        exu_valid = 0;
        chk("bp_b_valid", lsu_valid, 1);
        chk("bp_b_data", lsu_data, {32'h0000_00BB, 5'd4, 1'b0});
        wbu_ready = 1;
        step();
        wbu_ready = 0;

        // reset while waiting for the read response
        exu_valid = 1;
        exu_data = mk(32'h4000_0000, 0, 1, 0, 3'b010, 5'd8, 1,
                      2'b01, 0);
        step();
        exu_valid = 0;
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        chk("ar_in_resp", mem_rsp_ready, 1);
        #2;
        rst = 0;
        #1;
        chk("ar_rsp_ready", mem_rsp_ready, 0);
        chk("ar_req_valid", mem_req_valid, 0);
        chk("ar_lsu_valid", lsu_valid, 0);
        chk("ar_lsu_ready", lsu_ready, 1);
        chk("ar_lsu_data", lsu_data, 0);
        step();
        rst = 1;
        mem_rdata = 32'hDEAD_DEAD;
        mem_rsp_valid = 1;
        step();
        mem_rsp_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("ar_stale_valid", lsu_valid, 0);
            chk("ar_no_req", mem_req_valid, 0);
            step();
        end

        // stage still works after the abort
        run("post_rst", mk(32'h5000_0002, 0, 1, 0, 3'b000,
            5'd10, 1, 2'b01, 0), 32'h7F00_0000, 0, 0, 0,
            32'h0000_0000, 4'b0000, 0);

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
